// File: rtl/morse_text_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : morse_text_ctrl
// Brief    : Text line editor for decoded Morse characters. Codes go into a
//            working line; every v_sync fall copies it to the display buffer.
// Revision : 1.0 - initial release
// ============================================================================
module morse_text_ctrl #(
    parameter int          DEPTH = 8,
    parameter logic [4:0]  BLANK = 5'd26
) (
    input  logic                       board_clk,
    input  logic                       reset,
    input  logic                       letter_valid,
    input  logic [4:0]                 letter,
    output logic                       letter_ready,
    input  logic                       v_sync,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [4:0]                 rd_char,
    output logic [$clog2(DEPTH):0]     disp_count,
    output logic                       overflow
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    localparam logic [CW-1:0] c_full      = CW'(DEPTH);
    localparam logic [CW-1:0] c_cnt_one   = CW'(1);
    localparam logic [IW-1:0] c_idx_one   = IW'(1);
    localparam logic [IW-1:0] c_last_idx  = IW'(DEPTH - 1);
    localparam logic [4:0]    c_code_bs   = 5'd27;
    localparam logic [4:0]    c_code_clr  = 5'd28;
    localparam logic [4:0]    c_code_maxc = 5'd26;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        COPY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_copy_last;

    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic [IW-1:0]   r_copy_idx;
    logic [CW-1:0]   r_disp_count;
    logic [4:0]      r_rd_char;
    logic [4:0]      r_display [DEPTH];
    logic [4:0]      w_working [DEPTH];

    logic            r_sync1;
    logic            r_sync2;
    logic            r_sync_d;
    logic [1:0]      r_arm;
    logic            w_vs_fall;

    logic            w_accept;
    logic            w_is_char;
    logic            w_is_bs;
    logic            w_is_clr;
    logic            w_full;

    // ------------------------------------------------------------------
    // Code decode and handshake
    // ------------------------------------------------------------------
    assign letter_ready = (r_state == IDLE);
    assign w_accept     = letter_valid && letter_ready;
    assign w_is_char    = (letter <= c_code_maxc);
    assign w_is_bs      = (letter == c_code_bs);
    assign w_is_clr     = (letter == c_code_clr);
    assign w_full       = (r_count == c_full);

    // ------------------------------------------------------------------
    // v_sync synchronizer and falling-edge detector. The arm counter keeps
    // the detector blind until the history flop holds a real sample, so a
    // v_sync that is already low when reset releases does not trigger.
    // ------------------------------------------------------------------
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_sync_d <= 1'b1;
            r_arm    <= 2'd0;
        end else begin
            r_sync1  <= v_sync;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
            if (r_arm != 2'd3) begin
                r_arm <= r_arm + 2'd1;
            end
        end
    end

    assign w_vs_fall = r_sync_d && !r_sync2 && (r_arm == 2'd3);

    // ------------------------------------------------------------------
    // Working line: one register per cell, all updated from the same code
    // ------------------------------------------------------------------
    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        localparam logic [CW-1:0] c_pos     = CW'(i);
        localparam logic [CW-1:0] c_pos_nxt = CW'(i + 1);

        logic [4:0] r_cell;
        logic [4:0] w_shift_in;

        if (i == DEPTH - 1) begin : g_tail
            assign w_shift_in = letter;
        end else begin : g_body
            assign w_shift_in = w_working[i + 1];
        end

        always_ff @(posedge board_clk or posedge reset) begin
            if (reset) begin
                r_cell <= BLANK;
            end else if (w_accept) begin
                if (w_is_clr) begin
                    r_cell <= BLANK;
                end else if (w_is_char) begin
                    if (w_full) begin
                        r_cell <= w_shift_in;
                    end else if (r_count == c_pos) begin
                        r_cell <= letter;
                    end
                end else if (w_is_bs && (r_count == c_pos_nxt)) begin
                    r_cell <= BLANK;
                end
            end
        end

        assign w_working[i] = r_cell;
    end

    // ------------------------------------------------------------------
    // Line length and sticky scroll flag
    // ------------------------------------------------------------------
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            if (w_is_clr) begin
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else if (w_is_char) begin
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + c_cnt_one;
                end
            end else if (w_is_bs && (r_count != '0)) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Copy FSM
    // ------------------------------------------------------------------
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_copy_last = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_vs_fall) begin
                    w_state_nxt = COPY;
                end
            end
            COPY: begin
                if (r_copy_idx == c_last_idx) begin
                    w_copy_last = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            r_copy_idx   <= '0;
            r_disp_count <= '0;
        end else if (r_state == COPY) begin
            r_copy_idx <= w_copy_last ? '0 : (r_copy_idx + c_idx_one);
            if (w_copy_last) begin
                r_disp_count <= r_count;
            end
        end else begin
            r_copy_idx <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Display buffer and registered read port; a read colliding with the
    // cell being copied sees the pre-copy value.
    // ------------------------------------------------------------------
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_display[k] <= BLANK;
            end
            r_rd_char <= BLANK;
        end else begin
            if (r_state == COPY) begin
                r_display[r_copy_idx] <= w_working[r_copy_idx];
            end
            r_rd_char <= r_display[rd_idx];
        end
    end

    assign rd_char    = r_rd_char;
    assign disp_count = r_disp_count;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_morse_text_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_morse_text_ctrl
// Brief    : Self-checking bench for morse_text_ctrl (vector table, directed
//            corner sequences, randomized codes against a queue-based model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_morse_text_ctrl;

    localparam int DEPTH = 8;

    logic       board_clk;
    logic       reset;
    logic       letter_valid;
    logic [4:0] letter;
    logic       letter_ready;
    logic       v_sync;
    logic [2:0] rd_idx;
    logic [4:0] rd_char;
    logic [3:0] disp_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    morse_text_ctrl #(.DEPTH(DEPTH), .BLANK(5'd26)) dut (
        .board_clk    (board_clk),
        .reset        (reset),
        .letter_valid (letter_valid),
        .letter       (letter),
        .letter_ready (letter_ready),
        .v_sync       (v_sync),
        .rd_idx       (rd_idx),
        .rd_char      (rd_char),
        .disp_count   (disp_count),
        .overflow     (overflow)
    );

    initial begin
        board_clk = 1'b0;
        forever #5 board_clk = ~board_clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Reference model: the text line as a queue plus a display snapshot
    logic [4:0] m_line[$];
    bit         m_ovf;
    logic [4:0] m_disp [DEPTH];
    int         m_dcnt;

    function automatic void model_reset();
        m_line.delete();
        m_ovf  = 1'b0;
        m_dcnt = 0;
        for (int k = 0; k < DEPTH; k++) m_disp[k] = 5'd26;
    endfunction

    function automatic void model_apply(input logic [4:0] c);
        if (c <= 5'd26) begin
            if (m_line.size() == DEPTH) begin
                void'(m_line.pop_front());
                m_ovf = 1'b1;
            end
            m_line.push_back(c);
        end else if (c == 5'd27) begin
            if (m_line.size() > 0) void'(m_line.pop_back());
        end else if (c == 5'd28) begin
            m_line.delete();
            m_ovf = 1'b0;
        end
    endfunction

    function automatic void model_copy();
        for (int k = 0; k < DEPTH; k++)
            m_disp[k] = (k < m_line.size()) ? m_line[k] : 5'd26;
        m_dcnt = m_line.size();
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge board_clk);
        #1;
    endtask

    task automatic send_code(input logic [4:0] c);
        int n;
        letter       = c;
        letter_valid = 1'b1;
        n = 0;
        while (!letter_ready && n < 50) begin
            step();
            n++;
        end
        chk("send_ready", letter_ready, 1);
        step();
        letter_valid = 1'b0;
        model_apply(c);
        chk("send_overflow", overflow, m_ovf);
    endtask

    task automatic do_copy();
        int n;
        int m;
        v_sync = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (letter_ready && n < 10);
        chk("copy_start_latency", n, 3);
        m = 0;
        while (!letter_ready && m < 30) begin
            m++;
            step();
        end
        chk("copy_busy_cycles", m, DEPTH);
        v_sync = 1'b1;
        repeat (3) step();
        model_copy();
    endtask

    task automatic read_cell(input int idx, input string name, input int exp);
        rd_idx = 3'(idx);
        step();
        chk(name, rd_char, exp);
    endtask

    task automatic check_display();
        for (int k = 0; k < DEPTH; k++) read_cell(k, "disp_cell", m_disp[k]);
        chk("disp_count", disp_count, m_dcnt);
        chk("overflow", overflow, m_ovf);
    endtask

    typedef struct {
        logic [4:0] code;
        bit         do_cp;
        int         exp_ovf;
        int         exp_dcnt;
        int         exp_c0;
        int         exp_c1;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int m;
        int r;

        vecs[0] = '{5'd27, 1'b0, 0, 0, 0, 0};
        vecs[1] = '{5'd0,  1'b0, 0, 0, 0, 0};
        vecs[2] = '{5'd27, 1'b0, 0, 0, 0, 0};
        vecs[3] = '{5'd1,  1'b1, 0, 1, 1, 26};
        vecs[4] = '{5'd30, 1'b1, 0, 1, 1, 26};
        vecs[5] = '{5'd2,  1'b1, 0, 2, 1, 2};
        vecs[6] = '{5'd28, 1'b1, 0, 0, 26, 26};

        reset        = 1'b1;
        letter_valid = 1'b0;
        letter       = 5'd0;
        v_sync       = 1'b1;
        rd_idx       = 3'd0;
        model_reset();
        step();
        step();
        chk("rst_ready", letter_ready, 1);
        chk("rst_rd_char", rd_char, 26);
        chk("rst_disp_count", disp_count, 0);
        chk("rst_overflow", overflow, 0);
        reset = 1'b0;
        repeat (5) step();

        // H, I then a copy
        send_code(5'd7);
        send_code(5'd8);
        do_copy();
        read_cell(0, "hi_cell0", 7);
        read_cell(1, "hi_cell1", 8);
        chk("hi_disp_count", disp_count, 2);
        send_code(5'd28);

        for (int v = 0; v < 7; v++) begin
            send_code(vecs[v].code);
            chk("tbl_overflow", overflow, vecs[v].exp_ovf);
            if (vecs[v].do_cp) begin
                do_copy();
                read_cell(0, "tbl_cell0", vecs[v].exp_c0);
                read_cell(1, "tbl_cell1", vecs[v].exp_c1);
                chk("tbl_disp_count", disp_count, vecs[v].exp_dcnt);
            end
        end

        // Nine letters scroll the line by one
        for (int k = 0; k < 9; k++) send_code(5'(k));
        do_copy();
        for (int k = 0; k < DEPTH; k++) read_cell(k, "scroll_cell", k + 1);
        chk("scroll_disp_count", disp_count, 8);
        chk("scroll_overflow", overflow, 1);

        // Clear after overflow, then ignored codes
        send_code(5'd28);
        chk("clear_overflow", overflow, 0);
        do_copy();
        for (int k = 0; k < DEPTH; k++) read_cell(k, "clear_cell", 26);
        chk("clear_disp_count", disp_count, 0);
        send_code(5'd29);
        send_code(5'd30);
        send_code(5'd31);
        do_copy();
        check_display();

        // Code accepted in the vs_fall cycle; second fall during COPY ignored
        v_sync = 1'b0;
        step();
        step();
        letter       = 5'd3;
        letter_valid = 1'b1;
        chk("sim_ready_before", letter_ready, 1);
        step();
        letter_valid = 1'b0;
        chk("sim_copy_started", letter_ready, 0);
        m = 0;
        for (int c = 0; c < 12; c++) begin
            if (!letter_ready) m++;
            if (c == 0) v_sync = 1'b1;
            if (c == 3) v_sync = 1'b0;
            step();
        end
        chk("sim_busy_cycles", m, DEPTH);
        v_sync = 1'b1;
        repeat (3) step();
        model_apply(5'd3);
        model_copy();
        read_cell(0, "sim_cell0", 3);
        chk("sim_disp_count", disp_count, 1);
        check_display();

        // Randomized codes against the model
        for (int it = 0; it < 150; it++) begin
            r = $urandom_range(0, 99);
            if (r < 65)      send_code(5'($urandom_range(0, 26)));
            else if (r < 80) send_code(5'd27);
            else if (r < 84) send_code(5'd28);
            else if (r < 90) send_code(5'($urandom_range(29, 31)));
            else begin
                do_copy();
                check_display();
            end
        end
        do_copy();
        check_display();

        // Reset during COPY cycle 4
        for (int k = 0; k < 9; k++) send_code(5'(k + 10));
        v_sync = 1'b0;
        repeat (6) step();
        chk("rmc_in_copy", letter_ready, 0);
        reset = 1'b1;
        #1;
        chk("rmc_ready", letter_ready, 1);
        chk("rmc_rd_char", rd_char, 26);
        chk("rmc_disp_count", disp_count, 0);
        chk("rmc_overflow", overflow, 0);
        model_reset();
        step();
        reset = 1'b0;
        m = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (!letter_ready) m++;
        end
        chk("rmc_no_spurious_copy", m, 0);
        v_sync = 1'b1;
        repeat (3) step();
        do_copy();
        check_display();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
